// File: rtl/multipit_if.sv
// multipit_if: configuration, status and interrupt signals of the multi-channel interval timer.
interface multipit_if #(
   parameter int CHANNELS       = 4,
   parameter int WIDTH          = 16,
   parameter int PRESCALE_WIDTH = 8
);
   localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   logic                      write_enable;
   logic [CH_BITS-1:0]        wr_channel;
   logic [WIDTH-1:0]          wr_reload;
   logic                      wr_repeating;
   logic                      wr_divider_on;
   logic [PRESCALE_WIDTH-1:0] prescale;
   logic [CHANNELS-1:0]       irq_clear;
   logic [CH_BITS-1:0]        rd_channel;
   logic [WIDTH-1:0]          rd_count;
   logic [CHANNELS-1:0]       counter_set;
   logic [CHANNELS-1:0]       interrupting;
   logic [CHANNELS-1:0]       pending;
   logic                      irq;
   modport master (
      output write_enable, wr_channel, wr_reload, wr_repeating, wr_divider_on,
             prescale, irq_clear, rd_channel,
      input  rd_count, counter_set, interrupting, pending, irq
   );
   modport slave (
      input  write_enable, wr_channel, wr_reload, wr_repeating, wr_divider_on,
             prescale, irq_clear, rd_channel,
      output rd_count, counter_set, interrupting, pending, irq
   );
endinterface

// File: rtl/multipit.sv
// multipit: CHANNELS independent down-counting interval timers sharing one prescaler.
module multipit #(
   parameter int CHANNELS       = 4,
   parameter int WIDTH          = 16,
   parameter int PRESCALE_WIDTH = 8
) (
   input logic       clk,
   input logic       reset,
   multipit_if.slave bus
);
   logic [PRESCALE_WIDTH-1:0] r_pcnt;
   logic [WIDTH-1:0]          r_count  [CHANNELS];
   logic [WIDTH-1:0]          r_reload [CHANNELS];
   logic [CHANNELS-1:0]       r_repeating, r_divider_on, r_set, r_int, r_pend;
   logic [CHANNELS-1:0]       w_wr, w_adv, w_exp;
   logic                      w_tick;
   // A write to a channel suppresses its advance, so a write in the expiry cycle wins.
   always_comb begin
      w_tick = r_pcnt >= bus.prescale;
      for (int c = 0; c < CHANNELS; c++) begin
         w_wr[c]  = bus.write_enable && (32'(bus.wr_channel) == c);
         w_adv[c] = r_set[c] && (!r_divider_on[c] || w_tick) && !w_wr[c];
         w_exp[c] = w_adv[c] && (r_count[c] == WIDTH'(1));
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pcnt       <= '0;
         r_repeating  <= '0;
         r_divider_on <= '0;
         r_set        <= '0;
         r_int        <= '0;
         r_pend       <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            r_count[c]  <= '0;
            r_reload[c] <= '0;
         end
      end else begin
         r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
         r_int  <= w_exp;
         r_pend <= (r_pend & ~bus.irq_clear) | w_exp;
         for (int c = 0; c < CHANNELS; c++) begin
            if (w_wr[c]) begin
               r_count[c]      <= bus.wr_reload;
               r_reload[c]     <= bus.wr_reload;
               r_repeating[c]  <= bus.wr_repeating;
               r_divider_on[c] <= bus.wr_divider_on;
               r_set[c]        <= |bus.wr_reload;
            end else if (w_adv[c]) begin
               r_count[c] <= w_exp[c] ? (r_repeating[c] ? r_reload[c] : '0) : r_count[c] - 1'b1;
               if (w_exp[c] && !r_repeating[c])
                  r_set[c] <= 1'b0;
            end
         end
      end
   end
   assign bus.rd_count     = (32'(bus.rd_channel) < CHANNELS) ? r_count[bus.rd_channel] : '0;
   assign bus.counter_set  = r_set;
   assign bus.interrupting = r_int;
   assign bus.pending      = r_pend;
   assign bus.irq          = |r_pend;
endmodule
